// File: rtl/timer_multi_if.sv
// Register-side bundle for the multi-channel timer: configuration in, per-channel status out.
interface timer_multi_if #(
    parameter int WIDTH          = 32,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 8
) ();
    logic [PRESCALE_WIDTH-1:0]          prescale_i;
    logic [CHANNELS-1:0]                en_i;
    logic [CHANNELS-1:0]                load_i;
    logic [CHANNELS-1:0]                periodic_i;
    logic [CHANNELS-1:0][WIDTH-1:0]     reload_i;
    logic [CHANNELS-1:0]                irq_clr_i;
    logic [CHANNELS-1:0][WIDTH-1:0]     count_o;
    logic [CHANNELS-1:0]                running_o;
    logic [CHANNELS-1:0]                timeout_o;
    logic [CHANNELS-1:0]                irq_o;

    modport master (
        output prescale_i, en_i, load_i, periodic_i, reload_i, irq_clr_i,
        input  count_o, running_o, timeout_o, irq_o
    );
    modport slave (
        input  prescale_i, en_i, load_i, periodic_i, reload_i, irq_clr_i,
        output count_o, running_o, timeout_o, irq_o
    );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel down-counting timer with a shared prescaler; each channel is
// one-shot or auto-reload and keeps a sticky expiry flag.
module timer_multi_ch #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tick,
    input  logic             en,
    input  logic             load,
    input  logic             periodic,
    input  logic             irq_clr,
    input  logic [WIDTH-1:0] reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             timeout,
    output logic             irq
);
    logic expire;

    // Load outranks the tick, so a reload on the expiry cycle suppresses the pulse.
    assign expire = !load && tick && running && en && (count == WIDTH'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count   <= '0;
            running <= 1'b0;
            timeout <= 1'b0;
            irq     <= 1'b0;
        end else begin
            timeout <= expire;
            if (expire)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;

            if (load) begin
                count   <= reload;
                running <= (reload != '0);
            end else if (expire) begin
                if (periodic && (reload != '0)) begin
                    count <= reload;
                end else begin
                    count   <= '0;
                    running <= 1'b0;
                end
            end else if (tick && running && en && (count > WIDTH'(1))) begin
                count <= count - WIDTH'(1);
            end
        end
    end
endmodule

module timer_multi #(
    parameter int WIDTH          = 32,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    timer_multi_if.slave bus
);
    logic [PRESCALE_WIDTH-1:0]      pre_q;
    logic                           active;
    logic                           tick;
    logic [CHANNELS-1:0][WIDTH-1:0] count;
    logic [CHANNELS-1:0]            running;
    logic [CHANNELS-1:0]            timeout;
    logic [CHANNELS-1:0]            irq;

    assign active = |(running & bus.en_i);
    // >= rather than == so shrinking prescale_i mid-count never wraps the divider.
    assign tick   = active && (pre_q >= bus.prescale_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            pre_q <= '0;
        else if (!active || tick)
            pre_q <= '0;
        else
            pre_q <= pre_q + PRESCALE_WIDTH'(1);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        timer_multi_ch #(.WIDTH(WIDTH)) u_ch (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .tick     (tick),
            .en       (bus.en_i[c]),
            .load     (bus.load_i[c]),
            .periodic (bus.periodic_i[c]),
            .irq_clr  (bus.irq_clr_i[c]),
            .reload   (bus.reload_i[c]),
            .count    (count[c]),
            .running  (running[c]),
            .timeout  (timeout[c]),
            .irq      (irq[c])
        );
    end

    assign bus.count_o   = count;
    assign bus.running_o = running;
    assign bus.timeout_o = timeout;
    assign bus.irq_o     = irq;
endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: expected timeout cycles are queued per channel
// when loads are driven and matched against observed pulses.
module tb_timer_multi;
    localparam int W  = 32;
    localparam int CH = 4;
    localparam int PW = 8;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_q [CH][$];

    timer_multi_if #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) bus ();

    timer_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Every observed pulse must match the oldest expected cycle for its channel.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            for (int c = 0; c < CH; c++) begin
                if (bus.timeout_o[c]) begin
                    chk($sformatf("tmo_expected_ch%0d", c), exp_q[c].size() > 0, 1);
                    if (exp_q[c].size() > 0)
                        chk($sformatf("tmo_cycle_ch%0d", c), cyc, exp_q[c].pop_front());
                end
            end
        end
    end

    initial begin
        int l;
        int nrel [CH];
        nrel = '{1, 3, 7, 15};

        bus.prescale_i = '0;
        bus.en_i       = '0;
        bus.load_i     = '0;
        bus.periodic_i = '0;
        bus.reload_i   = '0;
        bus.irq_clr_i  = '0;
        #2 rst_n_i = 1'b0;
        step(3);
        for (int c = 0; c < CH; c++) chk($sformatf("rst_count%0d", c), bus.count_o[c], 0);
        chk("rst_running", bus.running_o, 0);
        chk("rst_timeout", bus.timeout_o, 0);
        chk("rst_irq", bus.irq_o, 0);
        rst_n_i = 1'b1;

        // one-shot, prescale 0, reload 5
        bus.en_i = 4'b0001;
        bus.reload_i[0] = 5;
        bus.load_i = 4'b0001;
        exp_q[0].push_back(cyc + 6);
        step();
        bus.load_i = '0;
        for (int i = 5; i >= 1; i--) begin
            chk("t1_count", bus.count_o[0], i);
            chk("t1_running", bus.running_o[0], 1);
            step();
        end
        chk("t1_timeout", bus.timeout_o[0], 1);
        chk("t1_count_end", bus.count_o[0], 0);
        chk("t1_running_end", bus.running_o[0], 0);
        chk("t1_irq_set", bus.irq_o[0], 1);
        bus.irq_clr_i = 4'b0001;
        step();
        bus.irq_clr_i = '0;
        chk("t1_irq_clr", bus.irq_o[0], 0);

        // periodic, prescale 3, reload 2: period 8
        bus.prescale_i = 3;
        bus.en_i = 4'b0010;
        bus.periodic_i = 4'b0010;
        bus.reload_i[1] = 2;
        bus.load_i = 4'b0010;
        l = cyc + 1;
        for (int p = 1; p <= 4; p++) exp_q[1].push_back(l + 8 * p);
        step();
        bus.load_i = '0;
        for (int i = 0; i < 32; i++) begin
            chk("t2_count", bus.count_o[1], ((i % 8) < 4) ? 2 : 1);
            chk("t2_running", bus.running_o[1], 1);
            step();
        end
        bus.reload_i[1] = 0;
        bus.load_i = 4'b0010;
        step();
        bus.load_i = '0;
        chk("t2_disarm_running", bus.running_o[1], 0);
        chk("t2_disarm_count", bus.count_o[1], 0);

        // pause: prescale 2, reload 10, en dropped mid-prescale
        bus.prescale_i = 2;
        bus.en_i = 4'b0100;
        bus.reload_i[2] = 10;
        bus.load_i = 4'b0100;
        step();
        bus.load_i = '0;
        step(13);
        chk("t3_count_before_pause", bus.count_o[2], 6);
        bus.en_i = '0;
        repeat (6) begin
            step();
            chk("t3_count_hold", bus.count_o[2], 6);
            chk("t3_running_hold", bus.running_o[2], 1);
        end
        bus.en_i = 4'b0100;
        exp_q[2].push_back(cyc + 18);
        step(18);
        chk("t3_running_end", bus.running_o[2], 0);
        chk("t3_irq", bus.irq_o[2], 1);

        // load on the expiry tick wins; clear coincident with expiry loses
        bus.prescale_i = 0;
        bus.en_i = 4'b1001;
        bus.periodic_i = '0;
        bus.reload_i[0] = 3;
        bus.load_i = 4'b0001;
        step();
        bus.load_i = '0;
        step(2);
        chk("ca_count_pre", bus.count_o[0], 1);
        bus.load_i = 4'b0001;
        step();
        bus.load_i = '0;
        chk("ca_reload_count", bus.count_o[0], 3);
        chk("ca_reload_running", bus.running_o[0], 1);
        exp_q[0].push_back(cyc + 3);
        step(2);
        bus.irq_clr_i = 4'b0001;
        step();
        bus.irq_clr_i = '0;
        chk("cb_irq_set_wins", bus.irq_o[0], 1);
        chk("cb_running", bus.running_o[0], 0);

        // load 0 disarms a running channel without a pulse
        bus.reload_i[3] = 5;
        bus.load_i = 4'b1000;
        step();
        bus.load_i = '0;
        step(2);
        chk("cc_count_pre", bus.count_o[3], 3);
        bus.reload_i[3] = 0;
        bus.load_i = 4'b1000;
        step();
        bus.load_i = '0;
        chk("cc_running", bus.running_o[3], 0);
        chk("cc_count", bus.count_o[3], 0);
        step(8);
        chk("cc_irq", bus.irq_o[3], 0);

        // all channels periodic, prescale 1
        bus.prescale_i = 1;
        bus.en_i = 4'b1111;
        bus.periodic_i = 4'b1111;
        for (int c = 0; c < CH; c++) bus.reload_i[c] = nrel[c];
        bus.load_i = 4'b1111;
        l = cyc + 1;
        for (int c = 0; c < CH; c++)
            for (int t = l + 2 * nrel[c]; t <= l + 40; t += 2 * nrel[c])
                exp_q[c].push_back(t);
        step();
        bus.load_i = '0;
        step(41);
        chk("t4_irq_all", bus.irq_o, 4'hF);
        chk("t4_running_all", bus.running_o, 4'hF);
        rst_n_i = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) chk($sformatf("t4_rst_count%0d", c), bus.count_o[c], 0);
        chk("t4_rst_running", bus.running_o, 0);
        chk("t4_rst_timeout", bus.timeout_o, 0);
        chk("t4_rst_irq", bus.irq_o, 0);
        step(2);
        rst_n_i = 1'b1;
        step(5);
        chk("t4_post_running", bus.running_o, 0);
        chk("t4_post_irq", bus.irq_o, 0);
        chk("t4_post_count0", bus.count_o[0], 0);

        for (int c = 0; c < CH; c++) chk($sformatf("pending_tmo_ch%0d", c), exp_q[c].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
